irq_ctrl: RTL

Interrupt controller that sits between N peripheral interrupt sources (timers, GPIO edge) and the core's single int_vld/int_rdy interrupt port. It captures rising edges into a pending register and applies a per-source enable mask. It arbitrates by fixed or round-robin priority and issues one 1-cycle int_vld pulse per granted source. Software reaches it through a 4-word register window decoded by dbus.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_prio_pick.sv | 50 +++++
 rtl/irq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants for the interrupt controller: register window word
// addresses, CTRL/ID bit positions, source index width and FSM encoding.
// -----------------------------------------------------------------------------
package irq_pkg;

    // Source index width; covers up to 16 sources.
    localparam int IDX_W = 4;

    // Register window word addresses
    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_EN   = 2'd1;
    localparam logic [1:0] ADDR_ID   = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // CTRL bit positions
    localparam int CTRL_GIE = 0;
    localparam int CTRL_RR  = 1;

    // ID in-service flag position
    localparam int ID_INSVC = 15;

    // Grant FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/irq_prio_pick.sv
// -----------------------------------------------------------------------------
// irq_prio_pick
// Combinational winner search over the candidate vector.
//   cand    : pending & enabled sources (already gated by GIE)
//   rr_ptr  : round-robin search start index (always < N_SRC)
//   mode    : 0 = fixed priority (lowest index wins), 1 = round-robin
//   winner  : index of the selected source (0 when none)
//   any_vld : at least one candidate is set
// -----------------------------------------------------------------------------
module irq_prio_pick
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] cand,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] winner,
    output logic             any_vld
);

    localparam int SW = IDX_W + 1;

    // Widened so a 4-bit index can address every bit regardless of N_SRC.
    logic [15:0]   cand_ext;
    logic [SW-1:0] start;
    logic [SW-1:0] idx;

    assign cand_ext = 16'(cand);

    // Scan N_SRC slots beginning at start; the index wraps modulo N_SRC,
    // so fixed priority is simply a scan starting at 0.
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        idx     = '0;
        start   = mode ? {1'b0, rr_ptr} : '0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = start + SW'(i);
            if (idx >= SW'(N_SRC)) begin
                idx = idx - SW'(N_SRC);
            end
            if (!any_vld && cand_ext[idx[IDX_W-1:0]]) begin
                any_vld = 1'b1;
                winner  = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Interrupt controller: captures rising edges of N_SRC sources into a pending
// register, masks them with EN and GIE, picks a winner (fixed or round-robin)
// and delivers it to the core as a single-cycle int_vld pulse, then waits for
// the core to enter (int_rdy low) and leave (int_rdy high) its handler.
// Ports:
//   clk, rst (async, active-low)
//   irq_src   : raw source levels, rising edge is the event
//   reg_sel/reg_addr/reg_we/reg_din : register window write side
//   reg_dout  : combinational read data for reg_addr
//   int_vld   : interrupt pulse to the core
//   int_rdy   : core can accept an interrupt
// -----------------------------------------------------------------------------
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC   = 8,
    parameter int ACK_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             reg_sel,
    input  logic [1:0]       reg_addr,
    input  logic             reg_we,
    input  logic [15:0]      reg_din,
    output logic [15:0]      reg_dout,
    output logic             int_vld,
    input  logic             int_rdy
);

    localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO + 1) : 1;

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q,   pend_d;
    logic [N_SRC-1:0] en_q,     en_d;
    logic [IDX_W-1:0] id_q,     id_d;
    logic [1:0]       ctrl_q,   ctrl_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       state_q,  state_d;

    logic             wr_en;
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] grant_clr;
    logic [N_SRC-1:0] restore;
    logic [N_SRC-1:0] cand;
    logic [IDX_W-1:0] winner;
    logic             any_vld;
    logic             grant;
    logic             timeout;
    logic             unused_din;

    // Upper data bits are only meaningful for some registers / widths.
    assign unused_din = ^reg_din;

    assign wr_en   = reg_sel & reg_we;
    assign set_vec = irq_src & ~src_q;
    assign cand    = ctrl_q[CTRL_GIE] ? (pend_q & en_q) : '0;

    irq_prio_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .cand    (cand),
        .rr_ptr  (rr_ptr_q),
        .mode    (ctrl_q[CTRL_RR]),
        .winner  (winner),
        .any_vld (any_vld)
    );

    assign grant   = (state_q == ST_IDLE) && any_vld && int_rdy;
    assign timeout = (state_q == ST_WAIT_ACK) && int_rdy &&
                     (tmo_cnt_q == TMO_W'(ACK_TMO - 1));
    assign int_vld = (state_q == ST_ISSUE);

    // Register window, pending update and grant bookkeeping
    always_comb begin
        w1c = (wr_en && reg_addr == ADDR_PEND) ? reg_din[N_SRC-1:0] : '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_clr[i] = grant && (winner == IDX_W'(i));
            restore[i]   = timeout && (id_q == IDX_W'(i));
        end
        // New edges and timeout restores take precedence over any clear.
        pend_d = (pend_q & ~w1c & ~grant_clr) | set_vec | restore;
        en_d   = (wr_en && reg_addr == ADDR_EN) ? reg_din[N_SRC-1:0] : en_q;
        ctrl_d = (wr_en && reg_addr == ADDR_CTRL) ? reg_din[1:0] : ctrl_q;
        id_d   = grant ? winner : id_q;
        rr_ptr_d = rr_ptr_q;
        if (grant && ctrl_q[CTRL_RR]) begin
            rr_ptr_d = (winner == IDX_W'(N_SRC - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    // Grant FSM: one outstanding interrupt at a time
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_ISSUE;
                    tmo_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!int_rdy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout) begin
                    // Core never took it; the source is re-pended via restore.
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (int_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux has no side effects.
    always_comb begin
        reg_dout = '0;
        case (reg_addr)
            ADDR_PEND: reg_dout = 16'(pend_q);
            ADDR_EN:   reg_dout = 16'(en_q);
            ADDR_ID: begin
                reg_dout[IDX_W-1:0] = id_q;
                reg_dout[ID_INSVC]  = (state_q != ST_IDLE);
            end
            default:   reg_dout = {14'b0, ctrl_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q     <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            id_q      <= '0;
            ctrl_q    <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            src_q     <= irq_src;
            pend_q    <= pend_d;
            en_q      <= en_d;
            id_q      <= id_d;
            ctrl_q    <= ctrl_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
            state_q   <= state_d;
        end
    end

endmodule
